// File: rtl/strip_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | strip_sequencer_pkg : color width and sequencer state encodings    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package strip_sequencer_pkg;

   localparam int COLOR_BITS = 24;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEND   = 2'd1,
      ST_LATCH  = 2'd2,
      ST_FINISH = 2'd3
   } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/strip_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | strip_sequencer_if : buffer write, frame control and pixel stream  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface strip_sequencer_if
   import strip_sequencer_pkg::*;
#(
   parameter int ADDR_BITS = 3
);
   logic                  wr_en;
   logic [ADDR_BITS-1:0]  wr_addr;
   logic [COLOR_BITS-1:0] wr_data;
   logic                  start;
   logic                  busy;
   logic                  done;
   logic [COLOR_BITS-1:0] px_color;
   logic                  px_reset;
   logic                  px_valid;
   logic                  px_ready;

   modport slave (
      input  wr_en, wr_addr, wr_data, start, px_ready,
      output busy, done, px_color, px_reset, px_valid
   );

   modport master (
      output wr_en, wr_addr, wr_data, start, px_ready,
      input  busy, done, px_color, px_reset, px_valid
   );
endinterface
`default_nettype wire

// File: rtl/strip_sequencer_pixel_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pixel_buffer : NUM_PIXELS x COLOR_BITS register file, 1W / 1R comb |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pixel_buffer
   import strip_sequencer_pkg::*;
#(
   parameter int NUM_PIXELS = 8,
   parameter int ADDR_BITS  = 3
)(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  wr_en,
   input  logic [ADDR_BITS-1:0]  wr_addr,
   input  logic [COLOR_BITS-1:0] wr_data,
   input  logic [ADDR_BITS-1:0]  rd_addr,
   output logic [COLOR_BITS-1:0] rd_data
);
   logic [COLOR_BITS-1:0] r_mem [NUM_PIXELS];
   logic                  w_wr_in_range;

   // Only a partially populated address space needs an explicit range check.
   generate
      if ((1 << ADDR_BITS) == NUM_PIXELS) begin : g_full_range
         assign w_wr_in_range = 1'b1;
      end else begin : g_partial_range
         assign w_wr_in_range = (int'(wr_addr) < NUM_PIXELS);
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_PIXELS; i++) begin
            r_mem[i] <= '0;
         end
      end else if (wr_en && w_wr_in_range) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/strip_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | strip_sequencer : streams the pixel buffer, then a latch word      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module strip_sequencer
   import strip_sequencer_pkg::*;
#(
   parameter int NUM_PIXELS = 8,
   parameter int ADDR_BITS  = 3
)(
   input  logic              clk,
   input  logic              reset_n,
   strip_sequencer_if.slave  bus
);
   localparam logic [ADDR_BITS-1:0] c_last_index = ADDR_BITS'(NUM_PIXELS - 1);

   seq_state_t            r_state;
   seq_state_t            w_state_next;
   logic [ADDR_BITS-1:0]  r_index;
   logic [ADDR_BITS-1:0]  w_index_next;
   logic [COLOR_BITS-1:0] w_rd_data;
   logic                  w_busy;
   logic                  w_done;
   logic                  w_px_valid;
   logic                  w_px_reset;
   logic [COLOR_BITS-1:0] w_px_color;

   pixel_buffer #(
      .NUM_PIXELS (NUM_PIXELS),
      .ADDR_BITS  (ADDR_BITS)
   ) u_buffer (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (bus.wr_en && !w_busy),
      .wr_addr (bus.wr_addr),
      .wr_data (bus.wr_data),
      .rd_addr (r_index),
      .rd_data (w_rd_data)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_index <= '0;
      end else begin
         r_state <= w_state_next;
         r_index <= w_index_next;
      end
   end

   // Outputs decode from state only; the buffer is frozen while busy, so the
   // presented word stays stable across stalls without extra registers.
   always_comb begin
      w_state_next = r_state;
      w_index_next = r_index;
      w_busy       = 1'b1;
      w_done       = 1'b0;
      w_px_valid   = 1'b0;
      w_px_reset   = 1'b0;
      w_px_color   = '0;
      case (r_state)
         ST_IDLE: begin
            w_busy = 1'b0;
            if (bus.start) begin
               w_state_next = ST_SEND;
               w_index_next = '0;
            end
         end
         ST_SEND: begin
            w_px_valid = 1'b1;
            w_px_color = w_rd_data;
            if (bus.px_ready) begin
               if (r_index == c_last_index) begin
                  w_state_next = ST_LATCH;
               end else begin
                  w_index_next = r_index + 1'b1;
               end
            end
         end
         ST_LATCH: begin
            w_px_valid = 1'b1;
            w_px_reset = 1'b1;
            if (bus.px_ready) begin
               w_state_next = ST_FINISH;
            end
         end
         ST_FINISH: begin
            w_done       = 1'b1;
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   assign bus.busy     = w_busy;
   assign bus.done     = w_done;
   assign bus.px_valid = w_px_valid;
   assign bus.px_reset = w_px_reset;
   assign bus.px_color = w_px_color;

endmodule
`default_nettype wire

// File: tb/tb_strip_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_strip_sequencer : scoreboard bench for 8-pixel and 1-pixel DUTs |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_strip_sequencer;
   import strip_sequencer_pkg::*;

   localparam int N  = 8;
   localparam int AB = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   strip_sequencer_if #(.ADDR_BITS(AB)) m ();
   strip_sequencer_if #(.ADDR_BITS(1))  s ();

   strip_sequencer #(.NUM_PIXELS(N), .ADDR_BITS(AB)) u_dut (
      .clk(clk), .reset_n(reset_n), .bus(m.slave));
   strip_sequencer #(.NUM_PIXELS(1), .ADDR_BITS(1)) u_dut_one (
      .clk(clk), .reset_n(reset_n), .bus(s.slave));

   int n_cmp = 0;
   int n_err = 0;
   int n_done_m = 0;
   int n_done_s = 0;
   int frames_m = 0;
   logic [24:0] sb_m [$];
   logic [24:0] sb_s [$];
   logic [23:0] model_buf [N];
   logic [23:0] model_one;
   bit          model_busy = 0;
   logic        held_m = 1'b0;
   logic [24:0] held_w = '0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic fail_now(input string name, input logic [31:0] got);
      n_cmp++;
      n_err++;
      $display("FAIL %s: got %h expected no event", name, got);
   endtask

   // Scoreboard monitor for the 8-pixel DUT
   always @(negedge clk) begin
      if (!reset_n) begin
         held_m = 1'b0;
      end else begin
         if (m.done) n_done_m++;
         if (held_m && !m.px_valid) fail_now("valid_dropped", held_w);
         if (m.px_valid) begin
            if (held_m) check("hold_stable", {m.px_reset, m.px_color}, held_w);
            if (m.px_ready) begin
               if (sb_m.size() == 0) fail_now("unexpected_word", {m.px_reset, m.px_color});
               else check("px_word", {m.px_reset, m.px_color}, sb_m.pop_front());
               held_m = 1'b0;
            end else begin
               held_m = 1'b1;
               held_w = {m.px_reset, m.px_color};
            end
         end else begin
            held_m = 1'b0;
         end
      end
   end

   // Scoreboard monitor for the 1-pixel DUT
   always @(negedge clk) begin
      if (reset_n) begin
         if (s.done) n_done_s++;
         if (s.px_valid && s.px_ready) begin
            if (sb_s.size() == 0) fail_now("one_unexpected_word", {s.px_reset, s.px_color});
            else check("one_px_word", {s.px_reset, s.px_color}, sb_s.pop_front());
         end
      end
   end

   task automatic write_px(input int addr, input logic [23:0] data);
      m.wr_en   = 1'b1;
      m.wr_addr = AB'(addr);
      m.wr_data = data;
      @(posedge clk); #1;
      m.wr_en = 1'b0;
      if (!model_busy && addr < N) model_buf[addr] = data;
   endtask

   // ready_mode: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random.
   // poke: start while busy and in the done cycle, plus writes while busy.
   task automatic run_frame(input int ready_mode, input bit poke, output int cyc);
      bit       seen = 0;
      bit [3:0] pat = 4'b1001;
      m.start    = 1'b1;
      model_busy = 1;
      frames_m++;
      for (int i = 0; i < N; i++) sb_m.push_back({1'b0, model_buf[i]});
      sb_m.push_back({1'b1, 24'h0});
      cyc = 0;
      for (int c = 1; c <= 300 && !seen; c++) begin
         @(negedge clk);
         if (m.done) begin
            seen = 1;
            cyc  = c;
         end
         @(posedge clk); #1;
         m.start   = poke && (c + 1 == 3 || c + 1 == N + 3);
         m.wr_en   = poke && (c + 1 == 4 || c + 1 == 5);
         m.wr_addr = (c + 1 == 4) ? AB'(3) : AB'(9);
         m.wr_data = 24'hFFFFFF;
         case (ready_mode)
            0:       m.px_ready = 1'b1;
            1:       m.px_ready = pat[c % 4];
            default: m.px_ready = 1'($urandom_range(0, 1));
         endcase
      end
      m.start = 1'b0;
      m.wr_en = 1'b0;
      if (!seen) fail_now("frame_timeout", 32'd300);
      model_busy = 0;
      check("frame_drained", sb_m.size(), 0);
   endtask

   initial begin
      int cyc;
      int done_before;
      m.wr_en = 0; m.wr_addr = '0; m.wr_data = '0; m.start = 0; m.px_ready = 0;
      s.wr_en = 0; s.wr_addr = '0; s.wr_data = '0; s.start = 0; s.px_ready = 0;
      for (int i = 0; i < N; i++) model_buf[i] = '0;
      model_one = '0;

      repeat (3) @(posedge clk); #1;
      check("rst_ctrl", {m.busy, m.done, m.px_valid, m.px_reset}, 0);
      check("rst_color", m.px_color, 0);
      check("rst_one_ctrl", {s.busy, s.done, s.px_valid, s.px_reset}, 0);
      reset_n = 1'b1;
      @(posedge clk); #1;
      check("idle_after_rst", {m.busy, m.done, m.px_valid}, 0);

      // Ramp pattern with a fully ready sink
      for (int i = 0; i < N; i++) write_px(i, 24'(i + 1));
      m.px_ready = 1'b1;
      run_frame(0, 0, cyc);
      check("done_latency", cyc, N + 3);

      // Stalling sink
      run_frame(1, 0, cyc);

      // Out-of-range writes while idle, then busy writes and stray starts
      write_px(9, 24'hABCDEF);
      write_px(15, 24'h123456);
      m.px_ready = 1'b1;
      run_frame(0, 1, cyc);
      check("poke_latency", cyc, N + 3);
      repeat (20) @(posedge clk); #1;
      check("single_done", n_done_m, frames_m);
      check("idle_after_poke", {m.busy, m.px_valid}, 0);
      run_frame(2, 0, cyc);

      // Randomized writes and sink behaviour
      repeat (6) begin
         repeat ($urandom_range(1, 6)) write_px($urandom_range(0, 15), 24'($urandom));
         run_frame(2, 0, cyc);
      end
      check("random_done_count", n_done_m, frames_m);

      // Abort after the fourth transfer
      m.px_ready = 1'b1;
      m.start    = 1'b1;
      model_busy = 1;
      for (int i = 0; i < N; i++) sb_m.push_back({1'b0, model_buf[i]});
      sb_m.push_back({1'b1, 24'h0});
      @(posedge clk); #1;
      m.start = 1'b0;
      repeat (4) @(posedge clk); #1;
      check("words_before_abort", sb_m.size(), N + 1 - 4);
      done_before = n_done_m;
      reset_n = 1'b0;
      #1;
      check("abort_ctrl", {m.busy, m.done, m.px_valid, m.px_reset}, 0);
      check("abort_color", m.px_color, 0);
      sb_m.delete();
      for (int i = 0; i < N; i++) model_buf[i] = '0;
      model_one  = '0;
      model_busy = 0;
      repeat (2) @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      check("quiet_after_abort", {m.busy, m.done, m.px_valid}, 0);
      check("no_done_on_abort", n_done_m, done_before);
      @(posedge clk); #1;
      run_frame(0, 0, cyc);
      check("zero_frame_latency", cyc, N + 3);

      // Single-pixel strip
      s.wr_en = 1'b1; s.wr_addr = 1'b0; s.wr_data = 24'($urandom);
      model_one = s.wr_data;
      @(posedge clk); #1;
      s.wr_addr = 1'b1; s.wr_data = 24'hFFFFFF;
      @(posedge clk); #1;
      s.wr_en = 1'b0;
      s.px_ready = 1'b1;
      s.start = 1'b1;
      sb_s.push_back({1'b0, model_one});
      sb_s.push_back({1'b1, 24'h0});
      cyc = 0;
      for (int c = 1; c <= 20 && cyc == 0; c++) begin
         @(negedge clk);
         if (s.done) cyc = c;
         @(posedge clk); #1;
         s.start = 1'b0;
      end
      if (cyc == 0) fail_now("one_timeout", 32'd20);
      check("one_latency", cyc, 4);
      check("one_drained", sb_s.size(), 0);
      check("one_done_count", n_done_s, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/strip_sequencer.md
STRIP_SEQUENCER -- requirements
Module: strip_sequencer

Interface
REQ-001 Parameter: NUM_PIXELS, default 8, number of pixels in the strip (1..256).
REQ-002 Parameter: ADDR_BITS, default 3, buffer address width; the design SHALL satisfy 2**ADDR_BITS >= NUM_PIXELS.
REQ-003 Port: clk  input  1  single system clock; all logic rising-edge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: wr_en  input  1  buffer write strobe.
REQ-006 Port: wr_addr  input  ADDR_BITS  pixel index to write.
REQ-007 Port: wr_data  input  24  GRB color for that pixel.
REQ-008 Port: start  input  1  single-cycle request to transmit one frame.
REQ-009 Port: busy  output  1  high while a frame is in progress.
REQ-010 Port: done  output  1  single-cycle pulse when a frame, including its latch, completes.
REQ-011 Port: px_color  output  24  color word to the downstream pixel_driver.
REQ-012 Port: px_reset  output  1  high marks the current word as a latch/reset command, not a color.
REQ-013 Port: px_valid  output  1  word on px_color/px_reset is valid.
REQ-014 Port: px_ready  input  1  downstream can accept a word this cycle.

Function
REQ-015 The block SHALL hold a NUM_PIXELS x 24 register-file buffer, written synchronously when wr_en is high, busy is low and wr_addr < NUM_PIXELS.
REQ-016 Writes while busy is high, or with wr_addr >= NUM_PIXELS, SHALL be ignored and SHALL leave the buffer unchanged.
REQ-017 The block SHALL implement the states IDLE, SEND, LATCH and FINISH.
REQ-018 IDLE -> SEND on start=1; the pixel index SHALL be cleared to 0, and px_valid=1 with px_color=buffer[0] and px_reset=0 SHALL appear on the next cycle.
REQ-019 A transfer SHALL occur on a cycle with px_valid=1 and px_ready=1; with no transfer, px_valid, px_color and px_reset SHALL hold stable.
REQ-020 In SEND, each transfer SHALL advance the index by 1 and present buffer[index], giving back-to-back transfers with no bubble when px_ready stays high.
REQ-021 A transfer of index NUM_PIXELS-1 SHALL move the block to LATCH, presenting px_valid=1, px_reset=1 and px_color=0.
REQ-022 A transfer in LATCH SHALL move the block to FINISH, with px_valid=0.
REQ-023 FINISH SHALL last exactly one cycle, assert done=1, and then return to IDLE.
REQ-024 busy SHALL be 1 in SEND, LATCH and FINISH, and 0 in IDLE.
REQ-025 start while busy=1 SHALL be ignored, with no queueing.
REQ-026 start in the same cycle that FINISH returns to IDLE SHALL be ignored; a new frame requires start while busy=0.
REQ-027 The index counter SHALL be ADDR_BITS wide and SHALL never exceed NUM_PIXELS-1, with no wrap within a frame.
REQ-028 When NUM_PIXELS=1, SEND SHALL transfer one word and then enter LATCH.
REQ-029 px_valid SHALL never deassert before its word transfers, except on reset.
REQ-030 A frame of N pixels with px_ready held at 1 SHALL take exactly N+3 cycles from the start edge to the done pulse, inclusive.

Reset
REQ-031 reset_n=0 SHALL immediately force the state to IDLE, the index to 0, and busy, done, px_valid and px_reset to 0, and px_color to 0.
REQ-032 Buffer contents SHALL be reset to 0.
REQ-033 A reset mid-frame SHALL abort the frame with no done pulse; outputs SHALL be quiet from the first clock after reset_n deasserts.

Structure
REQ-034 The shared include SHALL define COLOR_BITS=24 and the state encodings, to be used by both this block and pixel_driver.
REQ-035 The buffer SHALL be a sub-module named pixel_buffer (one synchronous write port, one combinational read port); the FSM and counter SHALL remain in strip_sequencer.

Verification
REQ-036 Write buffer[0..7]=0x000001..0x000008, px_ready=1, start pulse -> px_color 1..8 on consecutive cycles, then px_reset=1, and done=1 exactly 11 cycles after start.
REQ-037 px_ready toggling 1,0,0,1 during SEND -> each word is held stable while stalled, each is transferred exactly once, and the order is preserved.
REQ-038 Writing buffer[3]=0xFFFFFF while busy, and writing wr_addr=9 with NUM_PIXELS=8 -> the next frame shows the old buffer[3] and no corruption.
REQ-039 start pulsed while busy and again in the FINISH cycle -> exactly one frame and one done pulse.
REQ-040 reset_n asserted after the 4th transfer -> outputs go to 0 immediately, no done pulse; a following start sends pixel 0 with all-zero buffer contents.
REQ-041 NUM_PIXELS=1, start -> one color word, one latch word, and done on cycle 4.
